rs_pipe_alu_seg: RTL and testbench
==================================

// Module: rs_pipe_alu_seg
// PURPOSE
// - Pipelined, segmented add/sub/accumulate ALU built on the adder_carry chain primitive, for operands wider than one carry chain.
// - Splits WIDTH into NSEG segments of SEG_WIDTH bits. One segment per pipeline stage; inter-segment carry is registered.
// - Instantiated by arithmetic techmaps and DSP-less accumulators where a flat $alu exceeds MAX_CARRY_CHAIN or misses timing.
// PARAMETERS
// - WIDTH      64  operand/result width, >= 2
// - SEG_WIDTH  16  bits per carry-chain segment, 2..MAX_CARRY_CHAIN; last segment may be narrower
// - SIGNED     0   1: OV flags two's-complement overflow; 0: OV tied 0
// - NSEG       derived: ceil(WIDTH/SEG_WIDTH); also the pipeline latency in cycles
// PORTS
// - C          in   1      clock, all state on rising edge
// - R          in   1      synchronous reset, active-high
// - IN_VALID   in   1      operation present on A/B/SUB/ACC/CLR
// - IN_READY   out  1      block accepts operation this cycle
// - A          in   WIDTH  operand A (ignored when ACC=1)
// - B          in   WIDTH  operand B
// - SUB        in   1      1: A-B (B inverted, carry-in 1); 0: A+B
// - ACC        in   1      1: accumulator replaces A (ACC_REG +/- B)
// - CLR        in   1      with ACC=1: accumulator treated as 0 for this op
// - OUT_VALID  out  1      Y/CO/OV valid
// - OUT_READY  in   1      downstream accepts result
// - Y          out  WIDTH  result
// - CO         out  1      carry out of MSB (borrow-not for SUB)
// - OV         out  1      signed overflow (SIGNED=1 only)
// BEHAVIOUR
// - Reset: IN_READY=0 during R, 1 the cycle after; OUT_VALID=0, Y=0, CO=0, OV=0; all stage valids and accumulator cleared.
// - Accept: transfer when IN_VALID&&IN_READY. Emit: transfer when OUT_VALID&&OUT_READY.
// - Stall: whole pipeline advances only when !OUT_VALID || OUT_READY; IN_READY equals that advance enable. No bubbles squeezed out; Y/CO/OV hold while stalled.
// - Latency: exactly NSEG cycles from accept to OUT_VALID when unstalled; throughput 1 op/cycle.
// - Stage k (0..NSEG-1) adds segment k of A',B' with carry-in = registered carry from stage k-1 of the same op (stage 0: SUB).
//   Input segments k>0 are skew-delayed k cycles; result segments k<NSEG-1 are deskewed to align at output.
// - B' = SUB ? ~B : B. A' = ACC ? (CLR ? 0 : ACC_REG) : A.
// - Accumulator: each stage holds its own ACC_REG segment, updated when an ACC op passes that stage.
//   Back-to-back ACC ops need no interlock: segment k of op n+1 sees segment k of op n one cycle later.
// - Mixing ACC and non-ACC ops: non-ACC ops leave ACC_REG untouched.
// - CO = carry out of final stage. OV (SIGNED=1) = carry-in XOR carry-out of MSB; computed in final stage.
// - Wrap-around: result is modulo 2^WIDTH; no saturation.
// - Last segment width = WIDTH - (NSEG-1)*SEG_WIDTH; NSEG=1 degenerates to a single registered stage, latency 1.
// - Reset mid-operation: in-flight ops discarded, no OUT_VALID for them, ACC_REG=0.
// - Simultaneous accept and emit while full: both occur, occupancy unchanged.
// STRUCTURE
// - Package rs_alu_pkg: function rs_nseg(WIDTH,SEG_WIDTH); localparam MAX_CARRY_CHAIN; constant for OV-disabled tie-off.
// - Sub-module rs_alu_seg: one segment stage. Holds the adder_carry chain, carry register, ACC_REG slice, SUB/ACC/CLR/valid pipeline bits.
// - Top: generate NSEG rs_alu_seg, input skew shift registers, output deskew registers, global advance enable.
// TESTING
// - Reset: R high 3 cycles with IN_VALID=1 -> IN_READY=0, OUT_VALID=0, Y=0 throughout; first accept on cycle after R falls.
// - Carry ripple: WIDTH=64, SEG=16, A=64'h0000_FFFF_FFFF_FFFF, B=1 -> after 4 cycles Y=64'h0001_0000_0000_0000, CO=0.
//   Also A=all-ones, B=1 -> Y=0, CO=1.
// - Subtract/overflow: SIGNED=1, A=64'h8000_0000_0000_0000, B=1, SUB=1 -> Y=64'h7FFF_FFFF_FFFF_FFFF, CO=1, OV=1.
// - Accumulate: CLR+ACC B=5, then ACC B=3 x3 back-to-back, SUB on last -> Y sequence 5,8,11,8; no bubble between results.
// - Backpressure: stream 8 ops, hold OUT_READY=0 for 5 cycles mid-stream -> IN_READY=0 while stalled;
//   Y held stable; all 8 results in order with no loss or duplication.
// - Odd width: WIDTH=37, SEG=16 (NSEG=3, last seg 5 bits), A=2^37-1, B=1 -> Y=0, CO=1, latency 3.

Source files
------------

// File: rtl/rs_alu_pkg.sv
// Shared constants, control bundle and sizing helper for the segmented pipelined ALU.
package rs_alu_pkg;

  localparam int MAX_CARRY_CHAIN = 64;

  // Value presented on OV when signed overflow reporting is disabled.
  localparam logic RS_OV_OFF = 1'b0;

  typedef struct packed {
    logic v;
    logic sub;
    logic acc;
    logic clr;
    logic co;
  } rs_ctl_t;

  localparam rs_ctl_t RS_CTL_IDLE = 5'b0_0000;

  function automatic int rs_nseg(input int width, input int seg_width);
    return (width + seg_width - 1) / seg_width;
  endfunction

endpackage

// File: rtl/rs_alu_seg.sv
// One pipeline stage: adds one operand segment with the carry handed over from the previous stage,
// and owns the matching slice of the accumulator.
module rs_alu_seg
  import rs_alu_pkg::*;
#(
  parameter int SW    = 16,
  parameter bit OV_EN = 1'b0
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          adv_i,
  input  rs_ctl_t       ctl_i,
  input  logic [SW-1:0] a_i,
  input  logic [SW-1:0] b_i,
  output rs_ctl_t       ctl_o,
  output logic [SW-1:0] s_o,
  output logic          ov_o
);

  rs_ctl_t       ctl_d, ctl_q;
  logic [SW-1:0] a_s, b_s, s_d, s_q, acc_d, acc_q;
  logic          co_s, ov_d, ov_q;

  // Operand select, segment add and accumulator next-state; ctl_i.co carries the incoming carry.
  always_comb begin
    b_s = ctl_i.sub ? ~b_i : b_i;
    if (ctl_i.acc) begin
      a_s = ctl_i.clr ? {SW{1'b0}} : acc_q;
    end else begin
      a_s = a_i;
    end
    {co_s, s_d} = {1'b0, a_s} + {1'b0, b_s} + {{SW{1'b0}}, ctl_i.co};
    ctl_d       = ctl_i;
    ctl_d.co    = co_s;
    ov_d        = OV_EN ? ((a_s[SW-1] == b_s[SW-1]) && (s_d[SW-1] != a_s[SW-1])) : RS_OV_OFF;
    acc_d       = (ctl_i.v && ctl_i.acc) ? s_d : acc_q;
  end

  // Stage registers; data only captured for valid ops so results hold across bubbles.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ctl_q <= RS_CTL_IDLE;
      s_q   <= {SW{1'b0}};
      ov_q  <= 1'b0;
      acc_q <= {SW{1'b0}};
    end else if (adv_i) begin
      if (ctl_i.v) begin
        ctl_q <= ctl_d;
        s_q   <= s_d;
        ov_q  <= ov_d;
      end else begin
        ctl_q.v <= 1'b0;
      end
      acc_q <= acc_d;
    end
  end

  assign ctl_o = ctl_q;
  assign s_o   = s_q;
  assign ov_o  = ov_q;

endmodule

// File: rtl/rs_pipe_alu_seg.sv
// Segmented add/sub/accumulate ALU: one carry-chain segment per stage, operands skewed in,
// results deskewed out, whole pipe advancing on a single enable.
module rs_pipe_alu_seg
  import rs_alu_pkg::*;
#(
  parameter int WIDTH     = 64,
  parameter int SEG_WIDTH = 16,
  parameter bit SIGNED    = 1'b0
) (
  input  logic             C,
  input  logic             R,
  input  logic             IN_VALID,
  output logic             IN_READY,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             SUB,
  input  logic             ACC,
  input  logic             CLR,
  output logic             OUT_VALID,
  input  logic             OUT_READY,
  output logic [WIDTH-1:0] Y,
  output logic             CO,
  output logic             OV
);

  localparam int NSEG   = rs_nseg(WIDTH, SEG_WIDTH);
  localparam int LAST_W = WIDTH - (NSEG - 1) * SEG_WIDTH;

  logic             adv_s;
  rs_ctl_t          ctl_in_s;
  rs_ctl_t          ctl_s [NSEG];
  logic [WIDTH-1:0] y_s;
  logic             ov_last_s;
  logic             unused_ctl_s;

  assign adv_s    = !OUT_VALID || OUT_READY;
  assign IN_READY = adv_s && !R;
  // Stage 0 carry-in is SUB, completing the two's-complement negate of B.
  assign ctl_in_s = '{v: IN_VALID && IN_READY, sub: SUB, acc: ACC, clr: CLR, co: SUB};

  for (genvar k = 0; k < NSEG; k++) begin : g_seg
    localparam int SW = (k == NSEG - 1) ? LAST_W : SEG_WIDTH;
    localparam int LO = k * SEG_WIDTH;

    logic [SW-1:0] a_s, b_s, s_s;
    rs_ctl_t       cin_s;
    logic          ov_s;

    if (k == 0) begin : g_head
      assign a_s   = A[LO +: SW];
      assign b_s   = B[LO +: SW];
      assign cin_s = ctl_in_s;
    end else begin : g_skew
      logic [SW-1:0] a_sr_q [k];
      logic [SW-1:0] b_sr_q [k];

      // Delay operand segment k by k advances so it meets its op at stage k.
      always_ff @(posedge C) begin
        if (R) begin
          for (int i = 0; i < k; i++) begin
            a_sr_q[i] <= {SW{1'b0}};
            b_sr_q[i] <= {SW{1'b0}};
          end
        end else if (adv_s) begin
          a_sr_q[0] <= A[LO +: SW];
          b_sr_q[0] <= B[LO +: SW];
          for (int i = 1; i < k; i++) begin
            a_sr_q[i] <= a_sr_q[i-1];
            b_sr_q[i] <= b_sr_q[i-1];
          end
        end
      end

      assign a_s   = a_sr_q[k-1];
      assign b_s   = b_sr_q[k-1];
      assign cin_s = ctl_s[k-1];
    end

    rs_alu_seg #(
      .SW    (SW),
      .OV_EN (SIGNED && (k == NSEG - 1))
    ) u_seg (
      .clk_i (C),
      .rst_i (R),
      .adv_i (adv_s),
      .ctl_i (cin_s),
      .a_i   (a_s),
      .b_i   (b_s),
      .ctl_o (ctl_s[k]),
      .s_o   (s_s),
      .ov_o  (ov_s)
    );

    if (k < NSEG - 1) begin : g_deskew
      localparam int D = NSEG - 1 - k;
      logic [SW-1:0] y_dq [D];
      logic          unused_ov_s;

      // Hold early result segments until the final stage catches up.
      always_ff @(posedge C) begin
        if (R) begin
          for (int i = 0; i < D; i++) begin
            y_dq[i] <= {SW{1'b0}};
          end
        end else if (adv_s) begin
          y_dq[0] <= s_s;
          for (int i = 1; i < D; i++) begin
            y_dq[i] <= y_dq[i-1];
          end
        end
      end

      assign y_s[LO +: SW] = y_dq[D-1];
      assign unused_ov_s   = ov_s;
    end else begin : g_tail
      assign y_s[LO +: SW] = s_s;
      assign ov_last_s     = ov_s;
    end
  end

  assign OUT_VALID    = ctl_s[NSEG-1].v;
  assign CO           = ctl_s[NSEG-1].co;
  assign OV           = ov_last_s;
  assign Y            = y_s;
  assign unused_ctl_s = ^{ctl_s[NSEG-1].sub, ctl_s[NSEG-1].acc, ctl_s[NSEG-1].clr};

endmodule

// File: tb/tb_rs_pipe_alu_seg.sv
// Bench for rs_pipe_alu_seg: directed table, multi-cycle corner sequences and a randomized
// stream against an arithmetic reference model; a second instance covers an odd width.
module tb_rs_pipe_alu_seg;

  typedef struct { logic iv; logic [63:0] a; logic [63:0] b; logic sub; logic acc; logic clr; } op_t;
  typedef struct { logic [63:0] y; logic co; logic ov; } exp_t;
  typedef struct { op_t op; exp_t e; } vec_t;

  logic C = 1'b0;
  always #5 C = ~C;

  logic        R, in_valid, sub, acc, clr, out_ready, in_ready, out_valid, co, ov;
  logic [63:0] a, b, y;
  logic        in_valid2, sub2, acc2, clr2, out_ready2, in_ready2, out_valid2, co2, ov2;
  logic [36:0] a2, b2, y2;

  rs_pipe_alu_seg #(.WIDTH(64), .SEG_WIDTH(16), .SIGNED(1'b1)) dut (
    .C(C), .R(R), .IN_VALID(in_valid), .IN_READY(in_ready), .A(a), .B(b), .SUB(sub), .ACC(acc),
    .CLR(clr), .OUT_VALID(out_valid), .OUT_READY(out_ready), .Y(y), .CO(co), .OV(ov));

  rs_pipe_alu_seg #(.WIDTH(37), .SEG_WIDTH(16), .SIGNED(1'b0)) dut2 (
    .C(C), .R(R), .IN_VALID(in_valid2), .IN_READY(in_ready2), .A(a2), .B(b2), .SUB(sub2), .ACC(acc2),
    .CLR(clr2), .OUT_VALID(out_valid2), .OUT_READY(out_ready2), .Y(y2), .CO(co2), .OV(ov2));

  int          vec_n = 0, err_n = 0, cyc = 0, emit_n = 0, first_cyc = -1, last_cyc = -1;
  exp_t        exp_q [$];
  logic [63:0] acc_m = 64'd0;
  logic [63:0] y_prev = 64'd0;
  logic        co_prev = 1'b0;
  bit          stall_prev = 1'b0, emitted = 1'b0, accepted = 1'b0;
  op_t         idle_op, op;
  exp_t        none;
  vec_t        tab [13];
  op_t         bp [8];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
    vec_n++;
    if (act !== req) begin
      err_n++;
      $display("FAIL %s: got %h, want %h", nm, act, req);
    end
  endtask

  // Sequential semantics: each op sees the accumulator left by the previous ACC op.
  function automatic exp_t model(input op_t o);
    exp_t              e;
    logic [63:0]       ao;
    logic signed [65:0] sr;
    logic [64:0]       ur;
    ao = o.acc ? (o.clr ? 64'd0 : acc_m) : o.a;
    if (o.sub) begin
      sr   = $signed({{2{ao[63]}}, ao}) - $signed({{2{o.b[63]}}, o.b});
      e.co = (ao >= o.b);
    end else begin
      sr   = $signed({{2{ao[63]}}, ao}) + $signed({{2{o.b[63]}}, o.b});
      ur   = {1'b0, ao} + {1'b0, o.b};
      e.co = ur[64];
    end
    e.y  = sr[63:0];
    e.ov = (sr[65:63] != 3'b000) && (sr[65:63] != 3'b111);
    if (o.acc) acc_m = e.y;
    return e;
  endfunction

  function automatic vec_t mk(input logic [63:0] va, vb, input logic vs, vac, vc,
                              input logic [63:0] ey, input logic eco, eov);
    vec_t v;
    v.op.iv = 1'b1; v.op.a = va; v.op.b = vb; v.op.sub = vs; v.op.acc = vac; v.op.clr = vc;
    v.e.y = ey; v.e.co = eco; v.e.ov = eov;
    return v;
  endfunction

  function automatic op_t rand_op();
    op_t o;
    int  k;
    o.iv = 1'b1;
    o.a  = {$urandom, $urandom};
    o.b  = {$urandom, $urandom};
    k    = $urandom_range(0, 3);
    if (k == 0) o.a = 64'hFFFF_FFFF_FFFF_FFFF ^ {32'd0, 32'($urandom_range(0, 3))};
    if (k == 1) o.b = {48'd0, 16'($urandom)};
    o.sub = 1'($urandom);
    o.acc = ($urandom_range(0, 3) == 0);
    o.clr = ($urandom_range(0, 3) == 0);
    return o;
  endfunction

  // One clock: drive at the falling edge, then check what the DUT presents this cycle.
  task automatic cycle(input op_t o, input logic ordy, input logic rst, input bit use_tab, input exp_t texp);
    exp_t e, m;
    @(negedge C);
    R = rst; in_valid = o.iv; a = o.a; b = o.b; sub = o.sub; acc = o.acc; clr = o.clr; out_ready = ordy;
    #1;
    cyc++;
    if (stall_prev) begin
      chk("stall_hold_valid", 64'(out_valid), 64'd1);
      chk("stall_hold_y", y, y_prev);
      chk("stall_hold_co", 64'(co), 64'(co_prev));
    end
    if (!R && out_valid && !out_ready) chk("stall_in_ready", 64'(in_ready), 64'd0);
    if (!R && !out_valid) chk("idle_in_ready", 64'(in_ready), 64'd1);
    emitted = 1'b0;
    if (out_valid && out_ready) begin
      emitted = 1'b1;
      emit_n++;
      if (first_cyc < 0) first_cyc = cyc;
      last_cyc = cyc;
      if (exp_q.size() == 0) begin
        vec_n++; err_n++;
        $display("FAIL unexpected_emit: got result %h, want no result", y);
      end else begin
        e = exp_q.pop_front();
        chk("y", y, e.y);
        chk("co", 64'(co), 64'(e.co));
        chk("ov", 64'(ov), 64'(e.ov));
      end
    end
    stall_prev = !R && out_valid && !out_ready;
    y_prev     = y;
    co_prev    = co;
    accepted   = o.iv && in_ready;
    if (accepted) begin
      m = model(o);
      exp_q.push_back(use_tab ? texp : m);
    end
  endtask

  task automatic drain(input string nm);
    for (int n = 0; n < 60 && exp_q.size() > 0; n++) cycle(idle_op, 1'b1, 1'b0, 1'b0, none);
    chk({nm, "_drain_left"}, 64'(exp_q.size()), 64'd0);
  endtask

  task automatic odd_run(input logic [36:0] ia, ib, input logic isub, input logic [36:0] ey, input logic eco);
    bit got = 1'b0;
    @(negedge C);
    in_valid2 = 1'b1; a2 = ia; b2 = ib; sub2 = isub;
    #1;
    chk("odd_in_ready", 64'(in_ready2), 64'd1);
    for (int n = 1; n <= 10; n++) begin
      @(negedge C);
      in_valid2 = 1'b0;
      #1;
      if (out_valid2) begin
        chk("odd_latency", 64'(n), 64'd3);
        chk("odd_y", 64'(y2), 64'(ey));
        chk("odd_co", 64'(co2), 64'(eco));
        got = 1'b1;
        break;
      end
    end
    if (!got) begin
      vec_n++; err_n++;
      $display("FAIL odd_timeout: got no result in 10 cycles, want one after 3");
    end
  endtask

  initial begin
    bit got;
    int i, t;
    idle_op = '{iv: 1'b0, a: 64'd0, b: 64'd0, sub: 1'b0, acc: 1'b0, clr: 1'b0};
    none    = '{y: 64'd0, co: 1'b0, ov: 1'b0};
    R = 1'b1; in_valid = 1'b0; a = 64'd0; b = 64'd0; sub = 1'b0; acc = 1'b0; clr = 1'b0; out_ready = 1'b1;
    in_valid2 = 1'b0; a2 = 37'd0; b2 = 37'd0; sub2 = 1'b0; acc2 = 1'b0; clr2 = 1'b0; out_ready2 = 1'b1;

    tab[0]  = mk(64'h0000_FFFF_FFFF_FFFF, 64'd1, 1'b0, 1'b0, 1'b0, 64'h0001_0000_0000_0000, 1'b0, 1'b0);
    tab[1]  = mk(64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 1'b0, 1'b0, 64'd0, 1'b1, 1'b0);
    tab[2]  = mk(64'h8000_0000_0000_0000, 64'd1, 1'b1, 1'b0, 1'b0, 64'h7FFF_FFFF_FFFF_FFFF, 1'b1, 1'b1);
    tab[3]  = mk(64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 1'b0, 1'b0, 64'h8000_0000_0000_0000, 1'b0, 1'b1);
    tab[4]  = mk(64'd5, 64'd7, 1'b1, 1'b0, 1'b0, 64'hFFFF_FFFF_FFFF_FFFE, 1'b0, 1'b0);
    tab[5]  = mk(64'd0, 64'd0, 1'b1, 1'b0, 1'b0, 64'd0, 1'b1, 1'b0);
    tab[6]  = mk(64'hDEAD_BEEF_0000_0000, 64'd5, 1'b0, 1'b1, 1'b1, 64'd5, 1'b0, 1'b0);
    tab[7]  = mk(64'd0, 64'd3, 1'b0, 1'b1, 1'b0, 64'd8, 1'b0, 1'b0);
    tab[8]  = mk(64'd0, 64'd3, 1'b0, 1'b1, 1'b0, 64'd11, 1'b0, 1'b0);
    tab[9]  = mk(64'd0, 64'd3, 1'b1, 1'b1, 1'b0, 64'd8, 1'b1, 1'b0);
    tab[10] = mk(64'd100, 64'd1, 1'b0, 1'b0, 1'b0, 64'd101, 1'b0, 1'b0);
    tab[11] = mk(64'd0, 64'd0, 1'b0, 1'b1, 1'b0, 64'd8, 1'b0, 1'b0);
    tab[12] = mk(64'h0123_4567_89AB_CDEF, 64'h1111_1111_1111_1111, 1'b0, 1'b0, 1'b0,
                 64'h1234_5678_9ABC_DF00, 1'b0, 1'b0);

    // Reset held three cycles with traffic offered.
    for (int k = 0; k < 3; k++) begin
      op = rand_op();
      cycle(op, 1'b1, 1'b1, 1'b0, none);
      chk("rst_in_ready", 64'(in_ready), 64'd0);
      chk("rst_out_valid", 64'(out_valid), 64'd0);
      chk("rst_y", y, 64'd0);
    end
    cycle(tab[0].op, 1'b1, 1'b0, 1'b1, tab[0].e);
    chk("first_accept", 64'(accepted), 64'd1);

    got = 1'b0;
    for (int n = 1; n <= 20; n++) begin
      cycle(idle_op, 1'b1, 1'b0, 1'b0, none);
      if (emitted) begin
        chk("latency", 64'(n), 64'd4);
        got = 1'b1;
        break;
      end
    end
    if (!got) begin
      vec_n++; err_n++;
      $display("FAIL latency_timeout: got no result in 20 cycles, want one after 4");
    end

    // Remaining table back-to-back: results must come out on consecutive cycles.
    first_cyc = -1;
    for (int k = 1; k < 13; k++) cycle(tab[k].op, 1'b1, 1'b0, 1'b1, tab[k].e);
    drain("tab");
    chk("no_bubble", 64'(last_cyc - first_cyc), 64'd11);

    // Backpressure: eight ops with five cycles of OUT_READY low mid-stream.
    for (int k = 0; k < 8; k++) bp[k] = rand_op();
    i = 0; t = 0; emit_n = 0;
    while (i < 8 && t < 100) begin
      cycle(bp[i], !(t >= 5 && t < 10), 1'b0, 1'b0, none);
      if (accepted) i++;
      t++;
    end
    drain("bp");
    chk("bp_accepts", 64'(i), 64'd8);
    chk("bp_count", 64'(emit_n), 64'd8);

    // Reset with ops in flight: nothing emerges and the accumulator restarts at zero.
    for (int k = 0; k < 2; k++) begin
      op = rand_op();
      op.acc = 1'b0;
      cycle(op, 1'b1, 1'b0, 1'b0, none);
    end
    cycle(idle_op, 1'b1, 1'b1, 1'b0, none);
    exp_q.delete();
    acc_m = 64'd0;
    stall_prev = 1'b0;
    for (int k = 0; k < 6; k++) begin
      cycle(idle_op, 1'b1, 1'b0, 1'b0, none);
      chk("rst_flush_valid", 64'(out_valid), 64'd0);
    end
    op = '{iv: 1'b1, a: 64'hFFFF_0000_FFFF_0000, b: 64'd7, sub: 1'b0, acc: 1'b1, clr: 1'b0};
    cycle(op, 1'b1, 1'b0, 1'b1, '{y: 64'd7, co: 1'b0, ov: 1'b0});
    drain("acc_after_rst");

    // Randomized stream with random backpressure.
    for (int k = 0; k < 400; k++) begin
      op = rand_op();
      op.iv = ($urandom_range(0, 4) != 0);
      cycle(op, ($urandom_range(0, 3) != 0), 1'b0, 1'b0, none);
    end
    drain("rand");

    // Odd width: three segments, last one five bits.
    odd_run(37'h1F_FFFF_FFFF, 37'd1, 1'b0, 37'd0, 1'b1);
    odd_run(37'h00_0000_FFFF, 37'd1, 1'b0, 37'h00_0001_0000, 1'b0);
    odd_run(37'd0, 37'd1, 1'b1, 37'h1F_FFFF_FFFF, 1'b0);
    odd_run(37'h10_0000_0000, 37'd1, 1'b1, 37'h0F_FFFF_FFFF, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", vec_n, err_n);
    $finish;
  end

endmodule
